song_recorder: RTL

//  Composer-mode sequencer that owns the song RAM write port of song_player.
//  - On entry to composer state: issues clear_ram_pulse, then waits out the RAM clear.
//  - While recording: quantizes the held key to beats and writes {end,note,duration} words.
//  - At finish: terminates the song with an END word.

---
 rtl/song_recorder.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/song_recorder.sv
// Composer-mode sequencer driving the song RAM write port: clears the RAM on
// entry to composer mode, then records held notes as {end,note,duration} words.
module song_recorder #(
  parameter logic [1:0]  COMPOSE_STATE = 2'd2,
  parameter int          CLEAR_CYCLES  = 130,
  parameter logic [8:0]  MAX_DUR       = 9'd511,
  parameter logic [15:0] END_WORD      = 16'h803C
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        beat,
  input  logic [1:0]  master_state,
  input  logic        record_button,
  input  logic [5:0]  note_in,
  output logic        clear_ram_pulse,
  output logic        write_enable,
  output logic [6:0]  write_address,
  output logic [15:0] write_payload,
  output logic        recording,
  output logic        ram_full
);

  typedef enum logic [2:0] {
    IDLE, CLEARING, ARMED, RECORD, FIN_NOTE, FIN_END, DONE
  } state_t;

  localparam logic [7:0] CLR_LAST  = 8'(CLEAR_CYCLES - 1);
  localparam logic [6:0] LAST_DATA = 7'd126;

  state_t      state, state_n;
  logic [1:0]  prev_master;
  logic [7:0]  clr_cnt, clr_cnt_n;
  logic [6:0]  addr, addr_n;
  logic [8:0]  dur, dur_n;
  logic [5:0]  cur_note, cur_note_n;
  logic        full_n, clr_n, we_n;
  logic [6:0]  wa_n;
  logic [15:0] wp_n;

  assign recording = (state == RECORD);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      prev_master     <= 2'd0;
      clr_cnt         <= 8'd0;
      addr            <= 7'd0;
      dur             <= 9'd0;
      cur_note        <= 6'd0;
      ram_full        <= 1'b0;
      clear_ram_pulse <= 1'b0;
      write_enable    <= 1'b0;
      write_address   <= 7'd0;
      write_payload   <= 16'd0;
    end else begin
      state           <= state_n;
      prev_master     <= master_state;
      clr_cnt         <= clr_cnt_n;
      addr            <= addr_n;
      dur             <= dur_n;
      cur_note        <= cur_note_n;
      ram_full        <= full_n;
      clear_ram_pulse <= clr_n;
      write_enable    <= we_n;
      write_address   <= wa_n;
      write_payload   <= wp_n;
    end
  end

  always_comb begin
    state_n    = state;
    clr_cnt_n  = clr_cnt;
    addr_n     = addr;
    dur_n      = dur;
    cur_note_n = cur_note;
    full_n     = ram_full;
    clr_n      = 1'b0;
    we_n       = 1'b0;
    wa_n       = write_address;
    wp_n       = write_payload;

    // Leaving composer mode abandons whatever is in flight, including a pending note.
    if (state != IDLE && master_state != COMPOSE_STATE) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (master_state == COMPOSE_STATE && prev_master != COMPOSE_STATE) begin
            clr_n     = 1'b1;
            state_n   = CLEARING;
            clr_cnt_n = 8'd0;
            full_n    = 1'b0;
          end
        end
        CLEARING: begin
          clr_cnt_n = clr_cnt + 8'd1;
          if (clr_cnt == CLR_LAST) state_n = ARMED;
        end
        ARMED: begin
          if (record_button) begin
            state_n    = RECORD;
            addr_n     = 7'd0;
            dur_n      = 9'd0;
            full_n     = 1'b0;
            cur_note_n = note_in;
          end
        end
        RECORD: begin
          if (record_button) begin
            state_n = FIN_NOTE;
          end else if (beat) begin
            if (note_in == cur_note && dur < MAX_DUR) begin
              dur_n = dur + 9'd1;
            end else begin
              if (dur != 9'd0) begin
                we_n   = 1'b1;
                wa_n   = addr;
                wp_n   = {1'b0, cur_note, dur};
                addr_n = addr + 7'd1;
                // Address 127 belongs to the END word, so a full RAM stops recording.
                if (addr == LAST_DATA) begin
                  full_n  = 1'b1;
                  state_n = FIN_END;
                end
              end
              cur_note_n = note_in;
              dur_n      = 9'd1;
            end
          end
        end
        FIN_NOTE: begin
          if (dur != 9'd0 && addr <= LAST_DATA) begin
            we_n   = 1'b1;
            wa_n   = addr;
            wp_n   = {1'b0, cur_note, dur};
            addr_n = addr + 7'd1;
            if (addr == LAST_DATA) full_n = 1'b1;
          end
          state_n = FIN_END;
        end
        FIN_END: begin
          we_n    = 1'b1;
          wa_n    = addr;
          wp_n    = END_WORD;
          state_n = DONE;
        end
        DONE: begin
          if (record_button) begin
            clr_n     = 1'b1;
            state_n   = CLEARING;
            clr_cnt_n = 8'd0;
            full_n    = 1'b0;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule
